mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter between the pipeline and the single backing memory/cache port. It serves the instruction fetch stage's read handshake (`if_read_*`) and the memory stage's read/write data port (`dm_*`). It issues one transaction at a time on `mem_*` and returns data with a one-cycle acknowledge pulse. A watchdog aborts memory transactions that never acknowledge.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `mem_ack` before abort; 0 disables the watchdog.
- `ERR_DATA`, default 32'hDEADBEEF: read data returned on a timed-out read.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `if_read_req` in 1: fetch read request, level.
- `if_read_addr` in 32: fetch address.
- `if_read_ack` out 1: one-cycle completion pulse to fetch.
- `if_read_data` out 32: fetch read data.
- `dm_req` in 1: data-port request, level.
- `dm_we` in 1: 1 = write, 0 = read.
- `dm_be` in 4: write byte enables.
- `dm_addr` in 32: data address.
- `dm_wdata` in 32: write data.
- `dm_ack` out 1: one-cycle completion pulse to the data port.
- `dm_rdata` out 32: data-port read data.
- `mem_req` out 1: memory request, held until `mem_ack` or abort.
- `mem_we` out 1: memory write enable.
- `mem_be` out 4: memory byte enables.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: memory completion.
- `bus_error` out 1: one-cycle pulse on watchdog abort.
- `err_addr` out 32: address of the last aborted transaction.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - No request: stay in IDLE.
  - One or more requests: select a winner and latch address, we, be and wdata into internal registers.
  - Fetch transactions are forced to `mem_we`=0, `mem_be`=4'hF and `mem_addr[1:0]`=0.
  - Data-port fields are forwarded unchanged.
  - Next state is BUSY; `mem_req` is high from the next cycle.
- BUSY
  - `mem_*` outputs are held stable while `mem_req`=1.
  - `mem_ack` sampled high: register `mem_rdata` into the winner's read-data output (read only), drop `mem_req`, pulse the winner's ack next cycle, go to DONE.
  - A write leaves `dm_rdata` unchanged.
- DONE
  - Lasts exactly one cycle; all requests are ignored.
  - This gives registered requesters one cycle to deassert their request after the ack.
  - Returns to IDLE. A request still high in IDLE is treated as a new transaction.
- Read-data outputs are registered and hold their value until the next completion for that port.
- Watchdog (when `TIMEOUT_CYCLES`>0)
  - Counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`: drop `mem_req`, ack the winner, return `ERR_DATA` on a read, pulse `bus_error`, load `err_addr`, go to DONE.
  - `mem_ack` in the same cycle as the limit counts as success, not abort.
- Reset, including mid-transaction
  - State goes to IDLE and any outstanding transaction is abandoned without an ack.
  - All outputs are 0 the cycle after `reset` is sampled high; this includes `mem_req`, both acks, both read-data outputs, `bus_error` and `err_addr`.

## Timing
- Request sampled in IDLE at cycle N, then `mem_req`=1 at N+1.
- `mem_ack` sampled at cycle M (M ≥ N+1), then ack and data at M+1 (DONE), then IDLE at M+2.
- Minimum request-to-ack latency is 2 cycles; minimum back-to-back issue interval is 3 cycles.
- Abort: the ack arrives at N+1+`TIMEOUT_CYCLES`.
- The ack is never asserted for more than one cycle, and never on both ports in the same cycle.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined
  - Under contention, the port not granted last wins.
  - The last-grant register resets to "data", so fetch wins the first tie.
  - The last-grant register updates only on grant.
- `MEM_ARB_ROUND_ROBIN_EN` undefined
  - Fixed priority: the data port always wins ties, because it carries the older instruction.
  - The last-grant register is absent.

## Structure
- Package `mem_arb_pkg` holds:
  - the state encoding (IDLE, BUSY, DONE);
  - the grant IDs `GNT_IF`=0 and `GNT_DM`=1;
  - the fetch byte-enable constant 4'hF.
- Sub-module `mem_arb_timer`: watchdog counter.
  - Inputs: `clr` and `en`.
  - Output: `expired`.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`; the sub-module is tied off when `TIMEOUT_CYCLES`=0.

## Test plan
- Fetch read of 0x104, memory acks 1 cycle after `mem_req` returning 0x8C220004:
  - `mem_addr`=0x104, `mem_we`=0;
  - `if_read_ack` pulses 2 cycles after the request with `if_read_data`=0x8C220004.
- Data write to 0x2002, `dm_be`=4'b0100, `dm_wdata`=0x00AB0000:
  - the `mem_*` fields are forwarded exactly;
  - `dm_ack` pulses;
  - `dm_rdata` is unchanged.
- Both ports request continuously:
  - with the macro, grants alternate IF, DM, IF, DM;
  - without it, DM wins every arbitration.
- `TIMEOUT_CYCLES`=4, memory never acks, fetch read of 0x40:
  - `mem_req` drops after 4 BUSY cycles;
  - `if_read_ack` is asserted with 0xDEADBEEF;
  - `bus_error` pulses and `err_addr`=0x40.
- `reset` asserted in BUSY:
  - next cycle `mem_req`=0 and state is IDLE;
  - a later `mem_ack` produces no requester ack.
- Fetch keeps `if_read_req` high through DONE:
  - no ack in DONE;
  - a second transaction issues from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states, grant IDs and
// the fixed byte-enable used for instruction fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    localparam logic [3:0] IF_BE = 4'hF;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter: counts enabled cycles since clr and flags the cycle in which
// the TIMEOUT_CYCLES-th enabled cycle completes (combinational expired).
module mem_arb_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    // count holds the number of completed stalled cycles, so the limit is hit
    // while the final one is still in progress
    assign expired = en && (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter of fetch and data ports onto one memory port; acks a
// requester one cycle after mem_ack (or watchdog abort). MEM_ARB_ROUND_ROBIN_EN selects round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_read_req,
    input  logic [31:0] if_read_addr,
    output logic        if_read_ack,
    output logic [31:0] if_read_data,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        bus_error,
    output logic [31:0] err_addr
);

    state_t state, state_nxt;
    logic   gnt;
    logic   gnt_nxt;
    logic   grant;
    logic   finish;
    logic   tmr_en;
    logic   expired;

    assign grant   = (state == ST_IDLE) && (if_read_req || dm_req);
    assign tmr_en  = (state == ST_BUSY) && !mem_ack;
    assign finish  = (state == ST_BUSY) && (mem_ack || expired);
    assign mem_req = (state == ST_BUSY);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_gnt;

    always_comb begin
        gnt_nxt = GNT_DM;
        if (if_read_req && dm_req) begin
            gnt_nxt = (last_gnt == GNT_DM) ? GNT_IF : GNT_DM;
        end else if (if_read_req) begin
            gnt_nxt = GNT_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt <= GNT_DM;
        end else if (grant) begin
            last_gnt <= gnt_nxt;
        end
    end
`else
    // data port carries the older instruction, so it wins ties
    assign gnt_nxt = dm_req ? GNT_DM : GNT_IF;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (grant) state_nxt = ST_BUSY;
            ST_BUSY: if (finish) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            mem_arb_timer #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
            ) u_timer (
                .clk     (clk),
                .reset   (reset),
                .clr     (grant),
                .en      (tmr_en),
                .expired (expired)
            );
        end else begin : g_no_wdog
            assign expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt          <= GNT_IF;
            mem_we       <= 1'b0;
            mem_be       <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_read_ack  <= 1'b0;
            if_read_data <= '0;
            dm_ack       <= 1'b0;
            dm_rdata     <= '0;
            bus_error    <= 1'b0;
            err_addr     <= '0;
        end else begin
            if_read_ack <= 1'b0;
            dm_ack      <= 1'b0;
            bus_error   <= 1'b0;
            if (grant) begin
                gnt <= gnt_nxt;
                if (gnt_nxt == GNT_IF) begin
                    mem_we    <= 1'b0;
                    mem_be    <= IF_BE;
                    mem_addr  <= if_read_addr & 32'hFFFF_FFFC;
                    mem_wdata <= '0;
                end else begin
                    mem_we    <= dm_we;
                    mem_be    <= dm_be;
                    mem_addr  <= dm_addr;
                    mem_wdata <= dm_wdata;
                end
            end
            // an ack in the limit cycle wins over the abort
            if (finish) begin
                if (gnt == GNT_IF) begin
                    if_read_ack  <= 1'b1;
                    if_read_data <= mem_ack ? mem_rdata : ERR_DATA;
                end else begin
                    dm_ack <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= mem_ack ? mem_rdata : ERR_DATA;
                    end
                end
                if (!mem_ack) begin
                    bus_error <= 1'b1;
                    err_addr  <= mem_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at stimulus
// time and matched against each requester ack.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_read_req;
    logic [31:0] if_read_addr;
    logic        if_read_ack;
    logic [31:0] if_read_data;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_error;
    logic [31:0] err_addr;

    mem_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .if_read_req (if_read_req),
        .if_read_addr(if_read_addr),
        .if_read_ack (if_read_ack),
        .if_read_data(if_read_data),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_be       (dm_be),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_be      (mem_be),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .bus_error   (bus_error),
        .err_addr    (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mem_dead   = 1'b0;
    bit   mem_manual = 1'b0;
    bit   man_ack    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h104) return 32'h8C220004;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // memory: acks in the first cycle mem_req is seen, unless dead or hand-driven
    always @(posedge clk) begin
        #2;
        if (mem_manual) begin
            mem_ack = man_ack;
        end else begin
            mem_ack = 1'b0;
            if (mem_req && !mem_dead) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_fn(mem_addr);
            end
        end
    end

    always @(negedge clk) begin
        if (if_read_ack || dm_ack) begin
            check("dual_ack", 32'(if_read_ack & dm_ack), 32'h0);
            check("sb_empty", 32'(sb.size() == 0), 32'h0);
            if (sb.size() != 0) begin
                e_cur = sb.pop_front();
                check("ack_port", 32'(dm_ack), 32'(e_cur.port));
                check("ack_data", e_cur.port ? dm_rdata : if_read_data, e_cur.data);
                if (e_cur.cyc >= 0) check("ack_cyc", cyc, e_cur.cyc);
                check("bus_err", 32'(bus_error), 32'(e_cur.err));
                if (e_cur.err) check("err_addr", err_addr, e_cur.eaddr);
            end
        end else if (bus_error) begin
            check("berr_no_ack", 32'(if_read_ack | dm_ack), 32'h1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks(input int n, output int busy_n);
        int seen;
        seen   = 0;
        busy_n = 0;
        for (int i = 0; i < 200 && seen < n; i++) begin
            @(posedge clk);
            #1;
            if (mem_req) busy_n++;
            if (if_read_ack || dm_ack) seen++;
        end
        check("ack_wait", seen, n);
    endtask

    initial begin
        int          bn;
        int          c;
        logic [31:0] dm_prev;
        logic        p;

        reset = 1'b1; if_read_req = 1'b0; if_read_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        idle(3);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_if_ack", 32'(if_read_ack), 32'h0);
        check("rst_dm_ack", 32'(dm_ack), 32'h0);
        check("rst_berr", 32'(bus_error), 32'h0);
        reset = 1'b0;
        idle(1);

        // fetch 0x104
        sb.push_back('{GNT_IF, 32'h8C220004, cyc + 2, 1'b0, 32'h0});
        if_read_addr = 32'h104; if_read_req = 1'b1;
        idle(1);
        check("f_req", 32'(mem_req), 32'h1);
        check("f_addr", mem_addr, 32'h104);
        check("f_we", 32'(mem_we), 32'h0);
        check("f_be", 32'(mem_be), 32'hF);
        wait_acks(1, bn);
        if_read_req = 1'b0;
        idle(1);

        // data read then data write; the write must leave dm_rdata alone
        dm_prev = rd_fn(32'h300);
        sb.push_back('{GNT_DM, dm_prev, cyc + 2, 1'b0, 32'h0});
        dm_addr = 32'h300; dm_we = 1'b0; dm_be = 4'hF; dm_req = 1'b1;
        wait_acks(1, bn);
        dm_req = 1'b0;
        idle(1);
        sb.push_back('{GNT_DM, dm_prev, cyc + 2, 1'b0, 32'h0});
        dm_addr = 32'h2002; dm_we = 1'b1; dm_be = 4'b0100; dm_wdata = 32'h00AB0000; dm_req = 1'b1;
        idle(1);
        check("w_addr", mem_addr, 32'h2002);
        check("w_we", 32'(mem_we), 32'h1);
        check("w_be", 32'(mem_be), 32'h4);
        check("w_wdata", mem_wdata, 32'h00AB0000);
        wait_acks(1, bn);
        dm_req = 1'b0; dm_we = 1'b0;
        idle(1);

        // watchdog abort of a fetch to 0x40
        mem_dead = 1'b1;
        sb.push_back('{GNT_IF, 32'hDEADBEEF, cyc + 1 + int'(TMO), 1'b1, 32'h40});
        if_read_addr = 32'h40; if_read_req = 1'b1;
        wait_acks(1, bn);
        check("to_busy", bn, TMO);
        check("to_req_drop", 32'(mem_req), 32'h0);
        if_read_req = 1'b0; mem_dead = 1'b0;
        idle(1);

        // fetch held through DONE issues a second transaction from IDLE
        c = cyc;
        sb.push_back('{GNT_IF, rd_fn(32'h108), c + 2, 1'b0, 32'h0});
        sb.push_back('{GNT_IF, rd_fn(32'h108), c + 5, 1'b0, 32'h0});
        if_read_addr = 32'h10B; if_read_req = 1'b1;
        idle(1);
        check("k_addr", mem_addr, 32'h108);
        wait_acks(2, bn);
        if_read_req = 1'b0;
        idle(1);

        // reset while BUSY, then a stray mem_ack
        mem_manual = 1'b1; man_ack = 1'b0;
        if_read_addr = 32'h500; if_read_req = 1'b1;
        idle(1);
        check("r_busy_req", 32'(mem_req), 32'h1);
        reset = 1'b1; if_read_req = 1'b0;
        idle(1);
        check("r_mem_req", 32'(mem_req), 32'h0);
        check("r_state", 32'(dut.state), 32'(ST_IDLE));
        check("r_if_data", if_read_data, 32'h0);
        check("r_dm_data", dm_rdata, 32'h0);
        check("r_err_addr", err_addr, 32'h0);
        check("r_mem_addr", mem_addr, 32'h0);
        reset = 1'b0; man_ack = 1'b1;
        idle(1);
        man_ack = 1'b0;
        idle(3);
        check("r_no_req", 32'(mem_req), 32'h0);
        mem_manual = 1'b0;
        idle(1);

        // both ports requesting continuously
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            p = (k % 2 == 0) ? GNT_IF : GNT_DM;
`else
            p = GNT_DM;
`endif
            sb.push_back('{p, p ? rd_fn(32'h300) : rd_fn(32'h200), c + 2 + 3 * k, 1'b0, 32'h0});
        end
        if_read_addr = 32'h200; dm_addr = 32'h300; dm_we = 1'b0; dm_be = 4'hF;
        if_read_req = 1'b1; dm_req = 1'b1;
        wait_acks(4, bn);
        if_read_req = 1'b0; dm_req = 1'b0;
        idle(4);
        check("sb_drained", sb.size(), 32'h0);
        check("end_mem_req", 32'(mem_req), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
